// File: rtl/quat_operand_loader.sv
// Serial-to-parallel operand loader for the quaternion multiplier: packs 8-word frames
// into operand pairs and queues them in a small FIFO. Optional macro QUAT_CONJ_EN adds b_conj.
module quat_operand_loader #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
`ifdef QUAT_CONJ_EN
  input  logic                       b_conj,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              a0,
  output logic [DW-1:0]              a1,
  output logic [DW-1:0]              a2,
  output logic [DW-1:0]              a3,
  output logic [DW-1:0]              b0,
  output logic [DW-1:0]              b1,
  output logic [DW-1:0]              b2,
  output logic [DW-1:0]              b3,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) ptr_inc = '0;
    else                   ptr_inc = p + PW'(1);
  endfunction

  function automatic logic [DW-1:0] neg_word(input logic [DW-1:0] x);
    neg_word = {DW{1'b0}} - x;
  endfunction

  // Entry layout: index 0..3 = a0..a3, 4..7 = b0..b3.
  logic [2:0]             cnt_q, cnt_d;
  logic [6:0][DW-1:0]     asm_q, asm_d;
  logic [7:0][DW-1:0]     mem_q [DEPTH];
  logic [7:0][DW-1:0]     mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [7:0][DW-1:0]     head_q, head_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   frame_err_q, frame_err_d;
  logic                   accept_s, push_s, pop_s, conj_s;
  logic [7:0][DW-1:0]     push_data_s;

`ifdef QUAT_CONJ_EN
  assign conj_s = b_conj;
`else
  assign conj_s = 1'b0;
`endif

  always_comb begin
    accept_s    = in_valid && in_ready_q;
    pop_s       = out_valid_q && out_ready;
    push_s      = accept_s && (cnt_q == 3'd7) && in_last;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    if (accept_s) begin
      // in_last must coincide exactly with the eighth word, otherwise drop the frame
      if (in_last != (cnt_q == 3'd7)) begin
        frame_err_d = 1'b1;
        cnt_d       = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd7) asm_d[cnt_q] = in_data;
      end
    end

    for (int i = 0; i < 7; i++) push_data_s[i] = asm_q[i];
    push_data_s[7] = in_data;
    if (conj_s) begin
      for (int i = 5; i < 8; i++) push_data_s[i] = neg_word(push_data_s[i]);
    end

    mem_d = mem_q;
    if (push_s) mem_d[wr_ptr_q] = push_data_s;
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // The next head may be the entry being written on this very edge
    if (level_d == '0)                           head_d = '0;
    else if (push_s && (rd_ptr_d == wr_ptr_q))   head_d = push_data_s;
    else                                         head_d = mem_q[rd_ptr_d];

    out_valid_d = (level_d != '0);
    in_ready_d  = !((cnt_d == 3'd7) && (level_d == LW'(DEPTH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 3'd0;
      asm_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign frame_err = frame_err_q;
  assign a0 = head_q[0];
  assign a1 = head_q[1];
  assign a2 = head_q[2];
  assign a3 = head_q[3];
  assign b0 = head_q[4];
  assign b1 = head_q[5];
  assign b2 = head_q[6];
  assign b3 = head_q[7];

endmodule

// File: tb/tb_quat_operand_loader.sv
// Directed self-checking bench for quat_operand_loader (DW=16, DEPTH=2).
module tb_quat_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        in_last = 1'b0;
  logic        b_conj = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [1:0]  level;
  logic        frame_err;
  logic [15:0] head [8];
  int          n_cmp = 0;
  int          n_err = 0;

  quat_operand_loader #(.DW(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef QUAT_CONJ_EN
    .b_conj(b_conj),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .level(level), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    head[0] = a0; head[1] = a1; head[2] = a2; head[3] = a3;
    head[4] = b0; head[5] = b1; head[6] = b2; head[7] = b3;
  end

  task automatic send_word(input logic [15:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_err++; $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) send_word(base + 16'(i), (i == 7));
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %0b want 0", frame_err); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== 16'd0) begin n_err++; $display("FAIL rst_data[%0d]: got %0h want 0", i, head[i]); end
    end
  endtask

  task automatic test_single_frame();
    send_frame(16'd1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== 16'(i + 1)) begin n_err++; $display("FAIL single_data[%0d]: got %0h want %0h", i, head[i], i + 1); end
    end
    pop_one();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %0b want 0", out_valid); end
    n_cmp++; if (a0 !== 16'd0 || b3 !== 16'd0) begin n_err++; $display("FAIL single_pop_zero: a0=%0h b3=%0h want 0", a0, b3); end
  endtask

  task automatic test_backpressure();
    send_frame(16'd1);
    send_frame(16'd9);
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL bp_level2: got %0d want 2", level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_early: got %0b want 1", in_ready); end
    for (int i = 0; i < 7; i++) send_word(16'(17 + i), 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_blocked: got %0b want 0", in_ready); end
    n_cmp++; if (a0 !== 16'd1) begin n_err++; $display("FAIL bp_head1: got %0h want 1", a0); end
    in_valid = 1'b1; in_data = 16'd24; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL bp_level_after_pop: got %0d want 1", level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_reopen: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL bp_level_refill: got %0d want 2", level); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== 16'(9 + i)) begin n_err++; $display("FAIL bp_head2[%0d]: got %0h want %0h", i, head[i], 9 + i); end
    end
    pop_one();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== 16'(17 + i)) begin n_err++; $display("FAIL bp_head3[%0d]: got %0h want %0h", i, head[i], 17 + i); end
    end
    pop_one();
    n_cmp++; if (level !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: level=%0d valid=%0b want 0/0", level, out_valid); end
  endtask

  task automatic test_frame_err();
    send_word(16'd100, 1'b0);
    send_word(16'd101, 1'b0);
    send_word(16'd102, 1'b1);
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_early_pulse: got %0b want 1", frame_err); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL ferr_early_nopush: got %0d want 0", level); end
    @(posedge clk); #1;
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_single_cycle: got %0b want 0", frame_err); end
    send_frame(16'd9);
    n_cmp++; if (a0 !== 16'd9 || b3 !== 16'd16) begin n_err++; $display("FAIL ferr_clean: a0=%0h b3=%0h want 9/10", a0, b3); end
    for (int i = 0; i < 8; i++) send_word(16'(48 + i), 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_late_pulse: got %0b want 1", frame_err); end
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL ferr_late_level: got %0d want 1", level); end
    n_cmp++; if (a0 !== 16'd9) begin n_err++; $display("FAIL ferr_late_head: got %0h want 9", a0); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 7; i++) send_word(16'(64 + i), 1'b0);
    out_ready = 1'b1;
    send_word(16'd71, 1'b1);
    out_ready = 1'b0;
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL simul_level: got %0d want 1", level); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== 16'(64 + i)) begin n_err++; $display("FAIL simul_head[%0d]: got %0h want %0h", i, head[i], 64 + i); end
    end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    send_frame(16'd1);
    send_word(16'd90, 1'b0);
    send_word(16'd91, 1'b0);
    send_word(16'd92, 1'b0);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (level !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_state: level=%0d valid=%0b want 0/0", level, out_valid); end
    n_cmp++; if (a0 !== 16'd0 || b3 !== 16'd0) begin n_err++; $display("FAIL midrst_data: a0=%0h b3=%0h want 0", a0, b3); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(16'd32);
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL midrst_level: got %0d want 1", level); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== 16'(32 + i)) begin n_err++; $display("FAIL midrst_head[%0d]: got %0h want %0h", i, head[i], 32 + i); end
    end
    pop_one();
  endtask

`ifdef QUAT_CONJ_EN
  task automatic test_conj();
    logic [15:0] exp_c [8];
    exp_c = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'hFFFF, 16'hFFFE, 16'hFFFD};
    for (int i = 0; i < 4; i++) send_word(16'(i + 1), 1'b0);
    send_word(16'd5, 1'b0); send_word(16'd1, 1'b0); send_word(16'd2, 1'b0);
    b_conj = 1'b1;
    send_word(16'd3, 1'b1);
    b_conj = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (head[i] !== exp_c[i]) begin n_err++; $display("FAIL conj_on[%0d]: got %0h want %0h", i, head[i], exp_c[i]); end
    end
    pop_one();
    for (int i = 0; i < 4; i++) send_word(16'(i + 1), 1'b0);
    send_word(16'd5, 1'b0); send_word(16'd1, 1'b0); send_word(16'd2, 1'b0);
    send_word(16'd3, 1'b1);
    n_cmp++; if (b1 !== 16'd1 || b2 !== 16'd2 || b3 !== 16'd3) begin n_err++; $display("FAIL conj_off: b1=%0h b2=%0h b3=%0h want 1/2/3", b1, b2, b3); end
    pop_one();
  endtask
`endif

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_frame_err();
    test_simultaneous();
    test_reset_midframe();
`ifdef QUAT_CONJ_EN
    test_conj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
